// File: rtl/demux_dispatch_if.sv
// Handshake/bus bundle for demux_dispatch.
//   slave  : view of the dispatch block (accepts words, drives y/s/out_valid/level)
//   master : view of the environment (source + downstream consumers)
// Signals: in_valid/in_ready/in_data/in_dest/rr_en (input port),
//          y/s/out_valid/ch_ready (routed output), level (FIFO occupancy).
interface demux_dispatch_if #(
  parameter int unsigned DW    = 5,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_dest;
  logic          rr_en;
  logic [DW-1:0] y;
  logic [1:0]    s;
  logic          out_valid;
  logic [3:0]    ch_ready;
  logic [LW-1:0] level;

  modport slave (
    input  in_valid, in_data, in_dest, rr_en, ch_ready,
    output in_ready, y, s, out_valid, level
  );

  modport master (
    output in_valid, in_data, in_dest, rr_en, ch_ready,
    input  in_ready, y, s, out_valid, level
  );
endinterface

// File: rtl/demux_dispatch.sv
// Upstream feeder for the 1-to-4 demux stage. Buffers DW-bit words in a
// DEPTH-entry FIFO, tags each with a 2-bit channel (source-supplied or
// round-robin) and presents the head as y/s until the addressed channel
// is ready.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : demux_dispatch_if.slave (input handshake, y/s/out_valid,
//           ch_ready, level)
module demux_dispatch #(
  parameter int unsigned DW    = 5,
  parameter int unsigned DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  demux_dispatch_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] Full = LW'(DEPTH);

  // Entry layout: {dest, data}
  typedef logic [DW+1:0] entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;

  logic          push, pop;
  logic          not_empty;
  logic [1:0]    dest;
  entry_t        head;

  assign head      = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);

  // All outputs come from registered state only; ch_ready never reaches in_ready.
  assign bus.in_ready  = (count_q != Full);
  assign bus.out_valid = not_empty;
  assign bus.level     = count_q;
  // Empty FIFO forces zeros so downstream never sees a stale entry.
  assign bus.y         = not_empty ? head[DW-1:0] : '0;
  assign bus.s         = not_empty ? head[DW+1:DW] : 2'd0;

  always_comb begin
    push     = bus.in_valid && (count_q != Full);
    pop      = not_empty && bus.ch_ready[head[DW+1:DW]];
    dest     = bus.rr_en ? rr_ptr_q : bus.in_dest;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (bus.rr_en) rr_ptr_d = rr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {dest, bus.in_data};
    end
  end
endmodule

// File: tb/tb_demux_dispatch.sv
module tb_demux_dispatch;
  localparam int unsigned DW    = 5;
  localparam int unsigned DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  demux_dispatch_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  demux_dispatch #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [1:0]    s;
    logic [DW-1:0] y;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned model_rr = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Acceptance capture: a word offered with in_ready high before the edge is
  // queued as expected output once the edge has happened.
  logic p_fire, p_rr;
  exp_t p_e;
  initial forever begin
    @(negedge clk);
    p_fire = rst_n && bus.in_valid && bus.in_ready;
    p_rr   = bus.rr_en;
    p_e.y  = bus.in_data;
    p_e.s  = bus.rr_en ? 2'(model_rr) : bus.in_dest;
    @(posedge clk);
    if (p_fire && rst_n) begin
      exp_q.push_back(p_e);
      if (p_rr) model_rr = (model_rr + 1) % 4;
    end
  end

  // Monitor: compares DUT outputs with the queue front each cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("level", 32'(bus.level), 32'(exp_q.size()));
      check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() != DEPTH));
      check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("y", 32'(bus.y), 32'(exp_q[0].y));
        check("s", 32'(bus.s), 32'(exp_q[0].s));
        if (bus.ch_ready[exp_q[0].s]) void'(exp_q.pop_front());
      end else begin
        check("y_idle", 32'(bus.y), 32'd0);
        check("s_idle", 32'(bus.s), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word; returns 1 ns after the accepting edge.
  task automatic push_word(input logic [DW-1:0] d, input logic [1:0] dst, input logic rr);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_dest  = dst;
    bus.rr_en    = rr;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL push_timeout: word %0h never accepted", d);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL drain_timeout: level=%0d, expected 0", bus.level);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic hold;
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_dest  = '0;
    bus.rr_en    = 1'b0;
    bus.ch_ready = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_s", 32'(bus.s), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // Single word to channel 2, consumed on the first cycle it is shown.
    bus.ch_ready = 4'b0100;
    push_word(5'h04, 2'd2, 1'b0);
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_y", 32'(bus.y), 32'h04);
    check("single_s", 32'(bus.s), 32'd2);
    drain(10);

    // Round-robin destinations, back-to-back.
    bus.ch_ready = 4'hF;
    for (int i = 0; i < 5; i++) push_word(DW'(5 + i), 2'd0, 1'b1);
    drain(20);

    // Backpressure: fifth word held while full.
    bus.ch_ready = 4'h0;
    fork
      for (int i = 0; i < 5; i++) push_word(DW'(5'h10 + i), 2'(i), 1'b0);
    join_none
    repeat (8) @(negedge clk);
    check("full_level", 32'(bus.level), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_head_y", 32'(bus.y), 32'h10);
    check("full_head_s", 32'(bus.s), 32'd0);
    step();
    bus.ch_ready = 4'hF;
    wait fork;
    drain(30);

    // Head-of-line blocking: dest 3 at head, only channel 0 ready.
    bus.ch_ready = 4'b0001;
    push_word(5'h0A, 2'd3, 1'b0);
    push_word(5'h0B, 2'd0, 1'b0);
    repeat (5) @(negedge clk);
    check("hol_s", 32'(bus.s), 32'd3);
    check("hol_y", 32'(bus.y), 32'h0A);
    check("hol_level", 32'(bus.level), 32'd2);
    step();
    bus.ch_ready = 4'b1000;
    step();
    bus.ch_ready = 4'hF;
    drain(20);

    // Simultaneous push and pop at level 2.
    bus.ch_ready = 4'h0;
    push_word(5'h11, 2'd1, 1'b0);
    push_word(5'h12, 2'd2, 1'b0);
    bus.ch_ready = 4'hF;
    push_word(5'h13, 2'd3, 1'b0);
    bus.ch_ready = 4'h0;
    @(negedge clk);
    check("pushpop_level", 32'(bus.level), 32'd2);
    check("pushpop_head", 32'(bus.y), 32'h12);
    step();
    bus.ch_ready = 4'hF;
    drain(20);

    // Randomized traffic; a refused word is held until accepted.
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!hold) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = DW'($urandom);
        bus.in_dest  = 2'($urandom);
        bus.rr_en    = 1'($urandom_range(0, 1));
      end
      bus.ch_ready = 4'($urandom);
      @(negedge clk);
      hold = bus.in_valid && !bus.in_ready;
    end
    step();
    bus.in_valid = 1'b0;
    bus.ch_ready = 4'hF;
    drain(40);

    // Asynchronous reset with 3 words queued.
    bus.ch_ready = 4'h0;
    for (int i = 0; i < 3; i++) push_word(DW'(5'h1A + i), 2'd1, 1'b0);
    #1 rst_n = 1'b0;
    exp_q.delete();
    model_rr = 0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_y", 32'(bus.y), 32'd0);
    check("arst_s", 32'(bus.s), 32'd0);
    check("arst_level", 32'(bus.level), 32'd0);
    #1 rst_n = 1'b1;
    step();
    bus.ch_ready = 4'hF;
    push_word(5'h1F, 2'd0, 1'b1);
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_y", 32'(bus.y), 32'h1F);
    check("post_rst_s", 32'(bus.s), 32'd0);
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
